mem_arbiter: RTL

//  Shares one SRAM-style memory port (mem_req/mem_gnt) between the CPU instruction-fetch port (I) and data port (D).

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_sat_ctr.sv | 31 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM state, owner encoding and the downstream command payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_D = 1'b0,
    ARB_OWN_I = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic              instr;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_sat_ctr.sv
// Saturating up-counter used for the arbiter wait-cycle statistics.
module mem_arb_sat_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single SRAM-style port, one transaction outstanding.
// Optional wait-cycle counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_gnt,
  output logic              imem_error,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_req,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [STRB_W-1:0] dmem_wstrb,
  output logic              dmem_gnt,
  output logic              dmem_error,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_req,
  output logic              mem_instr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_error,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PERF_W-1:0] perf_i_wait,
  output logic [PERF_W-1:0] perf_d_wait
);

  arb_state_e          state_q,  state_d;
  arb_owner_e          owner_q,  owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  mem_cmd_t            cmd_q,    cmd_d;
  logic                mem_req_q, mem_req_d;
  logic                starve_full;
  logic                i_win;
  logic                busy;

  assign starve_full = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign busy        = (state_q == ARB_BUSY);

  // Arbitrate in IDLE; hold the latched command in BUSY until the downstream strobe.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    i_win     = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (imem_req || dmem_req) begin
        i_win     = imem_req && (!dmem_req || starve_full);
        state_d   = ARB_BUSY;
        mem_req_d = 1'b1;
        if (i_win) begin
          owner_d     = ARB_OWN_I;
          starve_d    = '0;
          cmd_d.instr = 1'b1;
          cmd_d.wen   = 1'b0;
          cmd_d.addr  = imem_addr;
          cmd_d.wdata = '0;
          cmd_d.wstrb = '0;
        end else begin
          owner_d = ARB_OWN_D;
          // Count D grants that overtake a waiting fetch.
          if (imem_req && !starve_full) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          cmd_d.instr = 1'b0;
          cmd_d.wen   = dmem_wen;
          cmd_d.addr  = dmem_addr;
          cmd_d.wdata = dmem_wdata;
          cmd_d.wstrb = dmem_wstrb;
        end
      end
    end else if (mem_gnt) begin
      state_d   = ARB_IDLE;
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_OWN_D;
      starve_q  <= '0;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_instr = cmd_q.instr;
  assign mem_wen   = cmd_q.wen;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wstrb = cmd_q.wstrb;

  // A response is dropped if its owner has already withdrawn the request.
  assign imem_gnt   = mem_gnt && busy && (owner_q == ARB_OWN_I) && imem_req;
  assign dmem_gnt   = mem_gnt && busy && (owner_q == ARB_OWN_D) && dmem_req;
  assign imem_error = mem_error && imem_gnt;
  assign dmem_error = mem_error && dmem_gnt;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic i_wait_inc;
  logic d_wait_inc;

  assign i_wait_inc = imem_req && !(busy && (owner_q == ARB_OWN_I));
  assign d_wait_inc = dmem_req && !(busy && (owner_q == ARB_OWN_D));

  mem_arb_sat_ctr #(.W(PERF_W)) u_i_wait (
    .clk (g_clk),
    .rst (g_reset),
    .inc (i_wait_inc),
    .cnt (perf_i_wait)
  );

  mem_arb_sat_ctr #(.W(PERF_W)) u_d_wait (
    .clk (g_clk),
    .rst (g_reset),
    .inc (d_wait_inc),
    .cnt (perf_d_wait)
  );
`else
  assign perf_i_wait = '0;
  assign perf_d_wait = '0;
`endif

endmodule
